shift_add_mul: RTL and testbench

Iterative 32x32 unsigned multiplier controller that sequences one shared 32-bit ripple-carry adder (`adder_32bit`) over 32 shift-add iterations. It produces a 64-bit product behind a valid/ready handshake on both sides, and sits beside the ALU as the multi-cycle unit for M-extension multiply ops. The decode/issue logic selects the low or high product word.

---
 rtl/mul_seq_pkg.sv | 9 +
 rtl/adder_32bit.sv | 10 +
 rtl/shift_add_mul.sv | 77 +++++++
 tb/tb_shift_add_mul.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and iteration count for the shift-add multiplier.
package mul_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int MUL_ITER = 32;
endpackage

// File: rtl/adder_32bit.sv
// adder_32bit: 32-bit adder with carry in/out, shared by every multiply iteration.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative 32x32 unsigned multiplier, one shift-add step per cycle
// through a single shared adder, valid/ready handshake on operands and product.
module shift_add_mul
    import mul_seq_pkg::*;
#(
    parameter int ITER = MUL_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] prod,
    output logic        busy
);
    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_accept;
    logic        w_last;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == CALC);
    assign prod      = {r_hi, r_lo};
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_last    = (r_cnt == 5'(ITER - 1));

    adder_32bit u_add (
        .a    (r_hi),
        .b    (r_lo[0] ? r_mcand : 32'd0),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_accept ? CALC : IDLE;
            CALC:    w_next = flush ? IDLE : (w_last ? DONE : CALC);
            DONE:    w_next = (flush || out_ready) ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_accept) begin
                r_mcand <= a;
                r_hi    <= '0;
                r_lo    <= b;
                r_cnt   <= '0;
            end else if (r_state == CALC && !flush) begin
                // carry-out lands in hi[31]; the retired multiplier bit drops off lo[0]
                {r_hi, r_lo} <= {w_cout, w_sum, r_lo[31:1]};
                r_cnt        <= r_cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_shift_add_mul.sv
// tb_shift_add_mul: vector table, hand sequences and random regression against a*b.
module tb_shift_add_mul;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] prod;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs[6];

    shift_add_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e,
                          input int stall, input bit hold);
        int k;
        logic [63:0] want;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        sb.push_back(e);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        if (hold) begin
            a = ~x;
            b = ~y;
        end else begin
            in_valid = 1'b0;
        end
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(k), 64'd32);
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_prod", prod, e);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("out_valid", {63'd0, out_valid}, 64'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'(sb.size()), 64'd1);
        end else begin
            want = sb.pop_front();
            chk("prod", prod, want);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        bit          seen;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 0};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0};
        vecs[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 10};
        vecs[3] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 2};
        vecs[4] = '{32'h1234_5678,  32'd0,          64'd0,                   1};
        vecs[5] = '{32'd65536,      32'd65536,      64'h0000_0001_0000_0000, 0};

        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_prod", prod, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, 1'b0);

        // flush ten cycles into an op: no result, then a clean op
        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= out_valid;
            @(negedge clk);
        end
        chk("flush_no_valid", {63'd0, seen}, 64'd0);
        run_op(32'd7, 32'd6, 64'd42, 0, 1'b0);

        // reset pulse mid-calculation
        a = 32'h55;
        b = 32'h77;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("midrst_prod", prod, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        run_op(32'd0, 32'h1234_5678, 64'd0, 0, 1'b1);

        // reset pulse while holding a finished result
        a = 32'd11;
        b = 32'd13;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (34) @(negedge clk);
        chk("done_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("done_hold_prod", prod, 64'd143);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("donerst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("donerst_prod", prod, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            run_op(x, y, 64'(x) * 64'(y), int'($urandom_range(0, 3)), i[0]);
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
